// File: rtl/icache.sv
// Direct-mapped instruction cache: 16-byte lines, single-word fetch port, valid/ready line fill.
// Optional macro ICACHE_FLUSH_EN adds a flush input that invalidates every line.
module icache #(
  parameter int INDEX_WIDTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rdy,
  input  logic [31:0]  addr_from_fetcher,
  input  logic         valid_from_fetcher,
  output logic [31:0]  inst_to_fetcher,
  output logic         ready_to_fetcher,
  output logic [31:0]  addr_to_mem_ctrler,
  output logic         valid_to_mem_ctrler,
  input  logic [127:0] data_from_mem_ctrler,
  input  logic         ready_from_mem_ctrler
`ifdef ICACHE_FLUSH_EN
  ,
  input  logic         flush
`endif
);
  localparam int LINES     = 1 << INDEX_WIDTH;
  localparam int TAG_WIDTH = 28 - INDEX_WIDTH;

  typedef enum logic [0:0] {IDLE = 1'b0, MISS = 1'b1} state_e;

  state_e               state_q;
  logic [LINES-1:0]     valid_q;
  logic [TAG_WIDTH-1:0] tag_q  [LINES];
  logic [127:0]         data_q [LINES];
  logic [31:2]          miss_addr_q;
  logic [31:0]          inst_q;
  logic                 ready_q;
  logic                 mem_valid_q;
  logic                 flush_pend_q;

  logic                   flush_s;
  logic [INDEX_WIDTH-1:0] req_idx_s;
  logic [TAG_WIDTH-1:0]   req_tag_s;
  logic [INDEX_WIDTH-1:0] miss_idx_s;
  logic [TAG_WIDTH-1:0]   miss_tag_s;
  logic                   hit_s;
  logic                   accept_s;
  logic                   commit_s;
  logic                   unused_s;

  function automatic logic [31:0] sel_word(input logic [127:0] line, input logic [1:0] w);
    logic [31:0] r;
    case (w)
      2'd0:    r = line[31:0];
      2'd1:    r = line[63:32];
      2'd2:    r = line[95:64];
      2'd3:    r = line[127:96];
      default: r = 32'h0;
    endcase
    return r;
  endfunction

`ifdef ICACHE_FLUSH_EN
  assign flush_s = flush;
`else
  assign flush_s = 1'b0;
`endif

  assign req_idx_s  = addr_from_fetcher[3+INDEX_WIDTH:4];
  assign req_tag_s  = addr_from_fetcher[31:4+INDEX_WIDTH];
  assign miss_idx_s = miss_addr_q[3+INDEX_WIDTH:4];
  assign miss_tag_s = miss_addr_q[31:4+INDEX_WIDTH];
  assign unused_s   = ^addr_from_fetcher[1:0];

  // The response cycle is excluded because the fetcher still presents the request it just got.
  assign hit_s    = valid_q[req_idx_s] && (tag_q[req_idx_s] == req_tag_s);
  assign accept_s = valid_from_fetcher && rdy && !ready_q;
  assign commit_s = (state_q == MISS) && ready_from_mem_ctrler && !flush_s && !flush_pend_q;

  // Control FSM, valid bits and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      valid_q      <= '0;
      miss_addr_q  <= '0;
      inst_q       <= 32'h0;
      ready_q      <= 1'b0;
      mem_valid_q  <= 1'b0;
      flush_pend_q <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (flush_s) begin
            valid_q <= '0;
          end else if (accept_s && hit_s) begin
            inst_q  <= sel_word(data_q[req_idx_s], addr_from_fetcher[3:2]);
            ready_q <= 1'b1;
          end else if (accept_s) begin
            miss_addr_q  <= addr_from_fetcher[31:2];
            mem_valid_q  <= 1'b1;
            flush_pend_q <= 1'b0;
            state_q      <= MISS;
          end
        end
        MISS: begin
          // A flush during the fill poisons the returning line.
          if (flush_s) begin
            valid_q      <= '0;
            flush_pend_q <= 1'b1;
          end
          if (ready_from_mem_ctrler) begin
            mem_valid_q  <= 1'b0;
            flush_pend_q <= 1'b0;
            state_q      <= IDLE;
            if (commit_s) begin
              valid_q[miss_idx_s] <= 1'b1;
              inst_q              <= sel_word(data_from_mem_ctrler, miss_addr_q[3:2]);
              ready_q             <= 1'b1;
            end
          end
        end
        default: begin
          state_q     <= IDLE;
          mem_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Tag and data arrays; contents are only trusted behind valid_q.
  always_ff @(posedge clk) begin
    if (commit_s) begin
      data_q[miss_idx_s] <= data_from_mem_ctrler;
      tag_q[miss_idx_s]  <= miss_tag_s;
    end
  end

  assign inst_to_fetcher     = inst_q;
  assign ready_to_fetcher    = ready_q;
  assign valid_to_mem_ctrler = mem_valid_q;
  assign addr_to_mem_ctrler  = {miss_addr_q[31:4], 4'h0};

endmodule

// File: tb/tb_icache.sv
// Bench for icache: directed cases plus random fetches checked against a line-level cache model
// and a memory whose byte contents are a fixed function of the byte address.
module tb_icache;
  logic         clk = 1'b0;
  logic         rst;
  logic         rdy;
  logic [31:0]  addr_f;
  logic         valid_f;
  logic [31:0]  inst_to_fetcher;
  logic         ready_to_fetcher;
  logic [31:0]  addr_to_mem_ctrler;
  logic         valid_to_mem_ctrler;
  logic [127:0] data_from_mem;
  logic         ready_from_mem;
`ifdef ICACHE_FLUSH_EN
  logic         flush_in = 1'b0;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  bit          mvalid [16];
  logic [27:0] mline  [16];

  int          memreq_cnt = 0;
  logic [31:0] last_fill_addr = 32'h0;
  int          fill_cyc = 0;
  bit          mem_enable = 1'b1;
  int          force_lat = 0;
  logic        ready_prev = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  icache dut (
    .clk                   (clk),
    .rst                   (rst),
    .rdy                   (rdy),
    .addr_from_fetcher     (addr_f),
    .valid_from_fetcher    (valid_f),
    .inst_to_fetcher       (inst_to_fetcher),
    .ready_to_fetcher      (ready_to_fetcher),
    .addr_to_mem_ctrler    (addr_to_mem_ctrler),
    .valid_to_mem_ctrler   (valid_to_mem_ctrler),
    .data_from_mem_ctrler  (data_from_mem),
    .ready_from_mem_ctrler (ready_from_mem)
`ifdef ICACHE_FLUSH_EN
    ,
    .flush                 (flush_in)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Memory contents: 0x00001000 line holds bytes 0x00..0x0F, other 4K pages are scrambled.
  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    logic [19:0] t;
    t = (a[31:12] ^ 20'h1) * 20'h9D;
    return a[7:0] ^ t[7:0];
  endfunction

  function automatic logic [127:0] line_of(input logic [31:0] la);
    logic [127:0] l;
    for (int k = 0; k < 16; k++) l[8*k +: 8] = mem_byte({la[31:4], 4'h0} + 32'(k));
    return l;
  endfunction

  function automatic logic [31:0] word_of(input logic [31:0] a);
    logic [31:0] b;
    b = {a[31:2], 2'b00};
    return {mem_byte(b + 32'd3), mem_byte(b + 32'd2), mem_byte(b + 32'd1), mem_byte(b)};
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 16; i++) mvalid[i] = 1'b0;
  endtask

  // Line-fill responder with random latency.
  initial begin
    int lat;
    ready_from_mem = 1'b0;
    data_from_mem  = '0;
    forever begin
      @(negedge clk);
      if (mem_enable && valid_to_mem_ctrler === 1'b1) begin
        memreq_cnt++;
        last_fill_addr = addr_to_mem_ctrler;
        lat = (force_lat > 0) ? force_lat : int'($urandom_range(0, 3));
        repeat (lat) begin
          @(negedge clk);
          check("mem_req_hold", {31'h0, valid_to_mem_ctrler, addr_to_mem_ctrler},
                {31'h0, 1'b1, last_fill_addr});
        end
        ready_from_mem = 1'b1;
        data_from_mem  = line_of(last_fill_addr);
        fill_cyc       = cyc;
        @(negedge clk);
        ready_from_mem = 1'b0;
        check("mem_valid_drop", 64'(valid_to_mem_ctrler), 64'd0);
      end
    end
  end

  always @(negedge clk) begin
    if (ready_to_fetcher) check("single_pulse", 64'(ready_prev), 64'd0);
    ready_prev <= ready_to_fetcher;
  end

  // One fetch: hold the request until the response, keep it through the response cycle.
  task automatic fetch(input logic [31:0] a, input bit drop_rdy);
    int          idx;
    bit          exp_hit;
    logic [31:0] exp_inst;
    int          req0;
    int          cycles;
    bit          got;
    int          got_cyc;
    idx      = int'(a[7:4]);
    exp_hit  = mvalid[idx] && (mline[idx] == a[31:4]);
    exp_inst = word_of(a);
    req0     = memreq_cnt;
    addr_f   = a;
    valid_f  = 1'b1;
    cycles   = 0;
    got      = 1'b0;
    got_cyc  = 0;
    while (!got && cycles < 40) begin
      @(negedge clk);
      cycles++;
      if (drop_rdy && cycles == 1 && !exp_hit) rdy = 1'b0;
      if (ready_to_fetcher) begin
        got     = 1'b1;
        got_cyc = cyc;
      end
    end
    rdy = 1'b1;
    check("resp_seen", 64'(got), 64'd1);
    if (!got) begin
      valid_f = 1'b0;
      return;
    end
    check("inst", 64'(inst_to_fetcher), 64'(exp_inst));
    check("mem_reqs", 64'(memreq_cnt - req0), exp_hit ? 64'd0 : 64'd1);
    if (exp_hit) begin
      check("hit_latency", 64'(cycles), 64'd1);
    end else begin
      check("fill_addr", 64'(last_fill_addr), 64'({a[31:4], 4'h0}));
      check("miss_resp_cycle", 64'(got_cyc), 64'(fill_cyc + 1));
    end
    @(negedge clk);
    check("one_response", 64'(ready_to_fetcher), 64'd0);
    valid_f     = 1'b0;
    mvalid[idx] = 1'b1;
    mline[idx]  = a[31:4];
  endtask

  initial begin
    logic [31:0] a;
    rst     = 1'b0;
    rdy     = 1'b1;
    valid_f = 1'b0;
    addr_f  = 32'h0;
    clear_model();
    repeat (3) @(negedge clk);
    check("rst_ready", 64'(ready_to_fetcher), 64'd0);
    check("rst_mem_valid", 64'(valid_to_mem_ctrler), 64'd0);
    check("rst_inst", 64'(inst_to_fetcher), 64'd0);
    check("rst_mem_addr", 64'(addr_to_mem_ctrler), 64'd0);
    rst = 1'b1;

    fetch(32'h0000_1008, 1'b0);
    check("cold_inst", 64'(inst_to_fetcher), 64'h0B0A_0908);
    check("cold_fill_addr", 64'(last_fill_addr), 64'h0000_1000);
    fetch(32'h0000_100C, 1'b0);
    check("hit_inst", 64'(inst_to_fetcher), 64'h0F0E_0D0C);
    fetch(32'h0000_2000, 1'b0);
    fetch(32'h0000_1000, 1'b0);
    fetch(32'h0000_1004, 1'b0);
    fetch(32'h0000_1008, 1'b0);

    // rdy low blocks acceptance
    rdy     = 1'b0;
    addr_f  = 32'h0000_3010;
    valid_f = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("rdy_low_resp", 64'(ready_to_fetcher), 64'd0);
      check("rdy_low_memreq", 64'(valid_to_mem_ctrler), 64'd0);
    end
    rdy = 1'b1;
    fetch(32'h0000_3010, 1'b0);
    fetch(32'h0000_4024, 1'b1);

    // reset in the middle of a miss
    mem_enable = 1'b0;
    addr_f     = 32'h0000_5038;
    valid_f    = 1'b1;
    repeat (2) @(negedge clk);
    check("mid_miss_valid", 64'(valid_to_mem_ctrler), 64'd1);
    check("mid_miss_addr", 64'(addr_to_mem_ctrler), 64'h0000_5030);
    rst     = 1'b0;
    valid_f = 1'b0;
    @(negedge clk);
    check("rst_miss_ready", 64'(ready_to_fetcher), 64'd0);
    check("rst_miss_valid", 64'(valid_to_mem_ctrler), 64'd0);
    check("rst_miss_inst", 64'(inst_to_fetcher), 64'd0);
    check("rst_miss_addr", 64'(addr_to_mem_ctrler), 64'd0);
    rst        = 1'b1;
    mem_enable = 1'b1;
    clear_model();
    fetch(32'h0000_5038, 1'b0);
    fetch(32'h0000_1008, 1'b0);

`ifdef ICACHE_FLUSH_EN
    begin
      int req0;
      int pulses;
      int waited;
      fetch(32'h0000_1008, 1'b0);
      flush_in = 1'b1;
      @(negedge clk);
      flush_in = 1'b0;
      clear_model();
      fetch(32'h0000_1008, 1'b0);

      // flush while the fill is outstanding: first line discarded, request refetched
      force_lat = 6;
      req0      = memreq_cnt;
      addr_f    = 32'h0000_6044;
      valid_f   = 1'b1;
      @(negedge clk);
      flush_in = 1'b1;
      @(negedge clk);
      flush_in = 1'b0;
      pulses   = 0;
      repeat (6) begin
        @(negedge clk);
        if (ready_to_fetcher) pulses++;
      end
      check("flush_miss_no_resp", 64'(pulses), 64'd0);
      force_lat = 0;
      waited    = 0;
      while (!ready_to_fetcher && waited < 40) begin
        @(negedge clk);
        waited++;
      end
      check("flush_refetch_resp", 64'(ready_to_fetcher), 64'd1);
      check("flush_refetch_inst", 64'(inst_to_fetcher), 64'(word_of(32'h0000_6044)));
      check("flush_refetch_reqs", 64'(memreq_cnt - req0), 64'd2);
      @(negedge clk);
      valid_f = 1'b0;
      clear_model();
      mvalid[4] = 1'b1;
      mline[4]  = 28'h000_0604;
    end
`endif

    for (int n = 0; n < 200; n++) begin
      a = (32'($urandom_range(1, 4)) << 12) | (32'($urandom_range(0, 15)) << 4)
        | 32'($urandom_range(0, 15));
      fetch(a, $urandom_range(0, 3) == 0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
